// File: rtl/nrzi_toggle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : nrzi_toggle_decoder
// Description : Recovers T-bits from a toggle-encoded line, hunts for a sync
//               word, then delivers a fixed-length frame of words on a
//               valid/ready handshake with sticky overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module nrzi_toggle_decoder #(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] SYNC_PATTERN = 8'hD5,
    parameter int                FRAME_BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic              line_in,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              sync_found,
    output logic              frame_done,
    output logic              overrun
);

    localparam int               CNT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [7:0]       C_LAST_WORD = 8'(FRAME_BYTES - 1);

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_prev_line;
    logic [DATA_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [7:0]        r_word_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_sync_found;
    logic              r_frame_done;
    logic              r_overrun;

    logic              w_bit;
    logic [DATA_W-1:0] w_sh_next;
    logic              w_word_done;
    logic              w_drop;

    // A toggle on the line between two samples encodes a 1.
    assign w_bit       = line_in ^ r_prev_line;
    assign w_sh_next   = {w_bit, r_sh[DATA_W-1:1]};
    assign w_word_done = sample_en && (r_state == ST_DATA) && (r_bit_cnt == C_LAST_BIT);
    assign w_drop      = w_word_done && r_data_valid && !data_ready;

    // Framing: sync hunt and word/frame counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_HUNT;
            r_prev_line  <= 1'b0;
            r_sh         <= '0;
            r_bit_cnt    <= '0;
            r_word_cnt   <= '0;
            r_sync_found <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync_found <= 1'b0;
            r_frame_done <= 1'b0;
            if (sample_en) begin
                r_prev_line <= line_in;
                case (r_state)
                    ST_HUNT: begin
                        if (w_sh_next == SYNC_PATTERN) begin
                            r_state      <= ST_DATA;
                            r_sh         <= '0;
                            r_bit_cnt    <= '0;
                            r_word_cnt   <= '0;
                            r_sync_found <= 1'b1;
                        end else begin
                            r_sh <= w_sh_next;
                        end
                    end
                    ST_DATA: begin
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_bit_cnt <= '0;
                            if (r_word_cnt == C_LAST_WORD) begin
                                // Clearing the shifter keeps stale data bits from
                                // forming a false sync in the next hunt.
                                r_state      <= ST_HUNT;
                                r_sh         <= '0;
                                r_word_cnt   <= '0;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_sh       <= w_sh_next;
                                r_word_cnt <= r_word_cnt + 8'd1;
                            end
                        end else begin
                            r_sh      <= w_sh_next;
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    // Delivery: a completed word is dropped rather than overwriting an
    // unconsumed one; framing keeps advancing regardless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_word_done && !w_drop) begin
                r_data_out   <= w_sh_next;
                r_data_valid <= 1'b1;
            end else if (!w_word_done && r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (ovr_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign sync_found = r_sync_found;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nrzi_toggle_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nrzi_toggle_decoder
// Description : Self-checking bench with a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_nrzi_toggle_decoder;

    localparam int         DATA_W      = 8;
    localparam logic [7:0] SYNC        = 8'hD5;
    localparam int         FRAME_BYTES = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_en = 1'b0;
    logic       line_in = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       sync_found;
    logic       frame_done;
    logic       overrun;

    nrzi_toggle_decoder #(
        .DATA_W      (DATA_W),
        .SYNC_PATTERN(SYNC),
        .FRAME_BYTES (FRAME_BYTES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .line_in   (line_in),
        .ovr_clr   (ovr_clr),
        .data_out  (data_out),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .sync_found(sync_found),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: recovered bits kept as queues, words packed by weight.
    bit         m_level;
    bit         m_hunting;
    bit         m_win[$];
    bit         m_word[$];
    int         m_words;
    logic [7:0] e_data;
    bit         e_valid, e_sync, e_fdone, e_ovr;

    bit tx_level;
    int rdy_mode;       // 0: low, 1: high, 2: random
    bit clr_pend;
    bit clr_rand;

    function automatic logic [7:0] pack(input bit q[$]);
        logic [7:0] v;
        v = '0;
        for (int i = 0; i < q.size() && i < DATA_W; i++)
            if (q[i]) v = v + (8'd1 << i);
        return v;
    endfunction

    task automatic model_reset();
        m_level   = 1'b0;
        m_hunting = 1'b1;
        m_win.delete();
        for (int i = 0; i < DATA_W; i++) m_win.push_back(1'b0);
        m_word.delete();
        m_words = 0;
        e_data  = '0;
        e_valid = 0; e_sync = 0; e_fdone = 0; e_ovr = 0;
    endtask

    task automatic model_edge(input bit se, input bit li, input bit rdy, input bit clr);
        bit         b, done, set_ovr;
        logic [7:0] word;
        done = 0; set_ovr = 0; word = '0;
        e_sync = 0; e_fdone = 0;
        if (se) begin
            b = li ^ m_level;
            m_level = li;
            if (m_hunting) begin
                m_win.push_back(b);
                void'(m_win.pop_front());
                if (pack(m_win) == SYNC) begin
                    m_hunting = 0;
                    m_word.delete();
                    m_words = 0;
                    e_sync = 1;
                end
            end else begin
                m_word.push_back(b);
                if (m_word.size() == DATA_W) begin
                    done = 1;
                    word = pack(m_word);
                    m_word.delete();
                    m_words++;
                    if (m_words == FRAME_BYTES) begin
                        e_fdone   = 1;
                        m_hunting = 1;
                        m_win.delete();
                        for (int i = 0; i < DATA_W; i++) m_win.push_back(1'b0);
                    end
                end
            end
        end
        if (done) begin
            if (!e_valid || rdy) begin
                e_data  = word;
                e_valid = 1;
            end else begin
                set_ovr = 1;
            end
        end else if (e_valid && rdy) begin
            e_valid = 0;
        end
        if (set_ovr) e_ovr = 1;
        else if (clr) e_ovr = 0;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_out",   data_out,          e_data);
        chk("data_valid", {7'd0, data_valid}, {7'd0, e_valid});
        chk("sync_found", {7'd0, sync_found}, {7'd0, e_sync});
        chk("frame_done", {7'd0, frame_done}, {7'd0, e_fdone});
        chk("overrun",    {7'd0, overrun},    {7'd0, e_ovr});
    endtask

    task automatic cycle(input bit se);
        bit rdy, clr;
        case (rdy_mode)
            0:       rdy = 1'b0;
            1:       rdy = 1'b1;
            default: rdy = 1'($urandom_range(0, 1));
        endcase
        clr = clr_pend || (clr_rand && ($urandom_range(0, 7) == 0));
        sample_en  = se;
        line_in    = tx_level;
        data_ready = rdy;
        ovr_clr    = clr;
        @(posedge clk);
        model_edge(se, tx_level, rdy, clr);
        clr_pend = 0;
        #1;
        check_all();
    endtask

    task automatic send_bit(input bit b, input int gmax);
        repeat ($urandom_range(0, gmax)) cycle(1'b0);
        tx_level = tx_level ^ b;
        cycle(1'b1);
    endtask

    task automatic send_byte(input logic [7:0] v, input int gmax);
        for (int i = 0; i < DATA_W; i++) send_bit(v[i], gmax);
    endtask

    task automatic send_word(input logic [7:0] v, input int gmax, input int m_body, input int m_last);
        for (int i = 0; i < DATA_W; i++) begin
            rdy_mode = (i == DATA_W - 1) ? m_last : m_body;
            send_bit(v[i], gmax);
        end
    endtask

    function automatic bit early_match(input logic [4:0] p);
        logic [12:0] seq;
        logic [7:0]  win;
        seq = {SYNC, p};
        win = '0;
        for (int j = 0; j < 12; j++) begin
            win = {seq[j], win[7:1]};
            if (win == SYNC) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] prefix;
        rdy_mode = 1; clr_pend = 0; clr_rand = 0; tx_level = 0;
        model_reset();

        // Test 1: reset state, then sync from line level 0
        #12;
        check_all();
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_byte(SYNC, 0);
        chk("t1_sync_pulse", {7'd0, sync_found}, 8'd1);
        cycle(1'b0);
        chk("t1_sync_width", {7'd0, sync_found}, 8'd0);
        chk("t1_no_valid",   {7'd0, data_valid}, 8'd0);

        // Test 2: four words with ready high, then an undelivered hunt word
        send_word(8'h00, 0, 1, 1);
        chk("t2_w0", data_out, 8'h00);
        send_word(8'hFF, 0, 1, 1);
        chk("t2_w1", data_out, 8'hFF);
        send_word(8'hA5, 0, 1, 1);
        chk("t2_w2", data_out, 8'hA5);
        send_word(8'h3C, 0, 1, 1);
        chk("t2_w3", data_out, 8'h3C);
        chk("t2_fdone", {7'd0, frame_done}, 8'd1);
        send_byte(8'h00, 0);
        chk("t2_hunt_no_valid", {7'd0, data_valid}, 8'd0);

        // Test 3: consumer stalls over two words -> overrun, then clear
        rdy_mode = 1;
        send_byte(SYNC, 0);
        send_word(8'h11, 0, 0, 0);
        send_word(8'h22, 0, 0, 0);
        chk("t3_held_data", data_out, 8'h11);
        chk("t3_overrun",   {7'd0, overrun}, 8'd1);
        send_word(8'h33, 0, 1, 1);
        send_word(8'h44, 0, 1, 1);
        chk("t3_fdone", {7'd0, frame_done}, 8'd1);
        clr_pend = 1;
        cycle(1'b0);
        chk("t3_ovr_cleared", {7'd0, overrun}, 8'd0);

        // Test 4: completion coincides with a handshake
        rdy_mode = 1;
        send_byte(SYNC, 0);
        send_word(8'h11, 0, 0, 0);
        send_word(8'h66, 0, 0, 1);
        chk("t4_data",  data_out, 8'h66);
        chk("t4_valid", {7'd0, data_valid}, 8'd1);
        chk("t4_no_ovr", {7'd0, overrun}, 8'd0);
        send_word(8'h77, 0, 1, 1);
        send_word(8'h88, 0, 1, 1);

        // Test 5: random prefix and idle gaps ahead of sync
        rdy_mode = 1;
        do prefix = 5'($urandom_range(0, 31)); while (early_match(prefix));
        for (int i = 0; i < 5; i++) send_bit(prefix[i], 3);
        send_byte(SYNC, 3);
        chk("t5_sync", {7'd0, sync_found}, 8'd1);
        send_word(8'h5A, 3, 1, 1);
        chk("t5_data", data_out, 8'h5A);
        for (int i = 0; i < FRAME_BYTES - 1; i++)
            send_word(8'($urandom_range(0, 255)), 3, 1, 1);

        // Test 6: asynchronous reset in the middle of a word
        rdy_mode = 1;
        send_byte(SYNC, 0);
        send_word(8'h11, 0, 0, 0);
        rdy_mode = 0;
        for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_valid", {7'd0, data_valid}, 8'd0);
        check_all();
        tx_level = 0;
        line_in  = 1'b0;
        sample_en = 1'b0;
        @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;
        rdy_mode = 1;
        send_byte(SYNC, 0);
        chk("t6_resync", {7'd0, sync_found}, 8'd1);
        send_word(8'hC3, 0, 1, 1);
        chk("t6_data", data_out, 8'hC3);
        for (int i = 0; i < FRAME_BYTES - 1; i++) send_word(8'($urandom_range(0, 255)), 0, 1, 1);

        // Randomized frames: random noise, gaps, ready and overrun clears
        clr_rand = 1;
        for (int f = 0; f < 4; f++) begin
            rdy_mode = 2;
            repeat ($urandom_range(0, 6)) send_bit(1'($urandom_range(0, 1)), 2);
            send_byte(SYNC, 2);
            for (int w = 0; w < FRAME_BYTES; w++)
                send_word(8'($urandom_range(0, 255)), 2, 2, 2);
        end
        clr_rand = 0;
        repeat (4) cycle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nrzi_toggle_decoder.md
Name: nrzi_toggle_decoder

Overview:
- Receive-side decoder for toggle-encoded serial lines.
- A T-style toggle element drives the line: it toggles on bit 1 and holds on bit 0. This block recovers the original T bit stream by XOR against the previous sampled line level.
- It hunts for a sync byte, then assembles a fixed-length frame of DATA_W-bit words. Each word is delivered on a valid/ready handshake with overrun detection.
- Sits between a line sampler (which supplies a sample strobe) and a byte-wide consumer.

Parameters:
- DATA_W, 8, word width and sync width in bits.
- SYNC_PATTERN, 8'hD5, sync word (DATA_W bits, LSB received first); must be non-zero.
- FRAME_BYTES, 4, words per frame after sync (1..255).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- sample_en  input  1  one-cycle strobe: line_in is sampled this cycle.
- line_in  input  1  toggle-encoded line level.
- ovr_clr  input  1  clears the overrun flag.
- data_out  output  DATA_W  recovered word, LSB = first received bit.
- data_valid  output  1  data_out holds an unconsumed word.
- data_ready  input  1  consumer accepts data_out.
- sync_found  output  1  one-cycle pulse when the sync word matches.
- frame_done  output  1  one-cycle pulse when the last word of a frame completes.
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset (async, rst_n=0):
  - prev_line=0, state=HUNT, shift reg=0, bit_cnt=0, word_cnt=0.
  - data_out=0, data_valid=0, sync_found=0, frame_done=0, overrun=0.
  - Reset mid-frame discards all partial state immediately.
- Bit recovery, only on edges with sample_en=1:
  - bit = line_in ^ prev_line, then prev_line <= line_in.
  - Edges without sample_en change nothing except handshake and ovr_clr effects.
- Shift: sh <= {bit, sh[DATA_W-1:1]}, so the LSB-first word is complete after DATA_W shifts.
- State HUNT:
  - Shift on every sample.
  - If the post-shift value == SYNC_PATTERN: go to DATA, bit_cnt=0, word_cnt=0, sh cleared to 0, and sync_found=1 for the following cycle.
  - Sliding match: any bit alignment is accepted.
- State DATA:
  - Shift and increment bit_cnt.
  - On the DATA_W-th bit: the completed word is produced, bit_cnt=0, word_cnt++.
  - If word_cnt was FRAME_BYTES-1: frame_done=1 for one cycle, return to HUNT, sh=0 (prevents false sync from stale data bits).
- Word delivery (registered, latency 1 edge):
  - On the completing edge, if data_valid=0, or data_valid=1 and data_ready=1: data_out <= word, data_valid <= 1.
  - If data_valid=1 and data_ready=0: the word is dropped, data_out is held, overrun <= 1. Counters still advance, so framing is not disturbed.
  - Handshake with no completion: data_valid=1 and data_ready=1 -> data_valid <= 0. data_out keeps its value.
  - data_valid never deasserts without a handshake or a reset.
- overrun:
  - Cleared by ovr_clr=1 at an edge.
  - If a set event and ovr_clr occur on the same edge, set wins (overrun=1).
- Simultaneous sync and frame_done cannot occur on the same edge.
  - sync_found and frame_done are each exactly 1 cycle wide regardless of sample_en spacing.
- sample_en held continuously high is legal: one bit per clock.

Test Plan:
1. Reset, then line_in sequence 1,1,0,0,1,1,0,1, each bit with a sample_en strobe (sync D5 from an initial level of 0) -> sync_found pulses once, 1 cycle after the 8th sample; state=DATA; data_valid stays 0.
2. After sync, send 4 words 0x00,0xFF,0xA5,0x3C with data_ready=1 (line toggles per 1-bit) -> data_out shows each word with data_valid for exactly one cycle. frame_done pulses with the 0x3C word. A subsequent 0x00 word is not delivered (HUNT).
3. data_ready=0 during word 1 (0x11) and word 2 (0x22) -> data_out stays 0x11, overrun=1, frame_done still after word 4. Then ovr_clr=1 -> overrun=0.
4. Word completion on the same edge as a data_valid&data_ready handshake -> new word loaded, data_valid stays 1, overrun stays 0.
5. Prefix of 5 random bits before the sync, with sample_en gaps of 0-3 idle cycles -> sync still detected; subsequent word 0x5A decoded correctly.
6. Assert rst_n=0 after 3 data bits of word 2 with data_valid=1 -> all outputs 0 asynchronously. Resend the full sync and frame -> normal decode.
